pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder_pkg.sv | 18 +
 rtl/adder_chunk.sv | 40 ++++
 rtl/full_adder.sv | 21 ++
 rtl/pipelined_adder.sv | 170 +++++++++++++++++
 tb/tb_pipelined_adder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared definitions for the pipelined adder:
//     MODE_ADD / MODE_SUB : encodings of the SUB input
//     calc_stages()       : number of pipeline stages for a WIDTH/CHUNK pair
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Guarded against CHUNK < 1 so the parameter check in the top level can
    // report a readable error instead of a divide-by-zero during elaboration.
    function automatic int calc_stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
//   Combinational CHUNK-bit ripple-carry slice built from full_adder cells.
//   Ports:
//     a_i, b_i         CHUNK-bit operand slices
//     carry_in_i       carry into bit 0 of the slice
//     sum_o            CHUNK-bit sum slice
//     carry_out_o      carry out of the slice MSB
//     msb_carry_in_o   carry into the slice MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_in_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             carry_out_o,
    output logic             msb_carry_in_o
);

    // carry[i] is the carry into bit i; carry[CHUNK] leaves the slice.
    logic [CHUNK:0] carry;

    assign carry[0] = carry_in_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a_i     (a_i[i]),
            .b_i     (b_i[i]),
            .c_i     (carry[i]),
            .sum_o   (sum_o[i]),
            .carry_o (carry[i+1])
        );
    end

    assign carry_out_o    = carry[CHUNK];
    assign msb_carry_in_o = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     a_i, b_i  operand bits
//     c_i       carry in
//     sum_o     sum bit
//     carry_o   carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit add/subtract split into STAGES = WIDTH/CHUNK registered stages.
//   Stage k ripples operand slice k and registers the carry for stage k+1;
//   lower result slices travel alongside (skew pipeline). The whole pipeline
//   advances together when ADV = !OUT_VALID || OUT_READY and freezes otherwise.
//   Ports:
//     CLK, RESET        clock (rising edge), synchronous active-high reset
//     IN_VALID/IN_READY input handshake; IN_READY depends only on the output side
//     A, B              operands
//     CARRY_IN          carry-in for add; ignored in subtract mode
//     SUB               0: A+B+CARRY_IN, 1: A-B
//     OUT_VALID/OUT_READY output handshake
//     SUM               result modulo 2^WIDTH
//     CARRY             carry out of the MSB (subtract: 1 = no borrow)
//     OVERFLOW          two's-complement overflow of the signed result
// -----------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CARRY_IN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    // Subtraction is A + ~B + 1, so the carry-in is forced to 1.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = (SUB == MODE_SUB) ? ~B : B;
    assign cin_eff = (SUB == MODE_SUB) ? 1'b1 : CARRY_IN;

    logic adv;
    logic out_valid;

    assign out_valid = g_stage[STAGES-1].v_q;
    assign adv       = !out_valid || OUT_READY;
    assign IN_READY  = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;      // first bit resolved by this stage
        localparam int HI = LO + CHUNK;     // bits resolved once this stage is done

        logic [CHUNK-1:0] a_cur;
        logic [CHUNK-1:0] b_cur;
        logic [CHUNK-1:0] s_cur;
        logic             c_cur;
        logic             v_cur;
        logic             co_cur;
        logic             msb_ci;
        logic             load;

        logic [HI-1:0]    sum_d;
        logic [HI-1:0]    sum_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_src
            assign a_cur = A[CHUNK-1:0];
            assign b_cur = b_eff[CHUNK-1:0];
            assign c_cur = cin_eff;
            assign v_cur = IN_VALID;
            assign sum_d = s_cur;
        end else begin : g_src
            assign a_cur = g_stage[k-1].g_ops.a_q[LO +: CHUNK];
            assign b_cur = g_stage[k-1].g_ops.b_q[LO +: CHUNK];
            assign c_cur = g_stage[k-1].c_q;
            assign v_cur = g_stage[k-1].v_q;
            assign sum_d = {s_cur, g_stage[k-1].sum_q};
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i            (a_cur),
            .b_i            (b_cur),
            .carry_in_i     (c_cur),
            .sum_o          (s_cur),
            .carry_out_o    (co_cur),
            .msb_carry_in_o (msb_ci)
        );

        // Data registers only load with a valid beat, so bubbles never carry
        // stale or uninitialised data towards the outputs.
        assign load = adv && v_cur;

        always_ff @(posedge CLK) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the previous stage's old value on the same edge.
            if (RESET) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q <= v_cur;
                if (v_cur) begin
                    sum_q <= sum_d;
                    c_q   <= co_cur;
                end
            end
        end

        // Upper operand bits still waiting to be added by later stages.
        if (HI < WIDTH) begin : g_ops
            logic [WIDTH-1:HI] a_d;
            logic [WIDTH-1:HI] b_d;
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;

            if (k == 0) begin : g_first
                assign a_d = A[WIDTH-1:HI];
                assign b_d = b_eff[WIDTH-1:HI];
            end else begin : g_next
                assign a_d = g_stage[k-1].g_ops.a_q[WIDTH-1:HI];
                assign b_d = g_stage[k-1].g_ops.b_q[WIDTH-1:HI];
            end

            // NOTE: operand registers have no reset; they are only loaded
            // together with a valid beat and are never observed otherwise.
            always_ff @(posedge CLK) begin
                if (load) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // Signed overflow: carry into the MSB differs from carry out of it.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= msb_ci ^ co_cur;
                end
            end
        end else begin : g_no_ovf
            logic unused_msb_ci;
            assign unused_msb_ci = msb_ci;
        end
    end

    assign OUT_VALID = out_valid;
    assign SUM       = g_stage[STAGES-1].sum_q;
    assign CARRY     = g_stage[STAGES-1].c_q;
    assign OVERFLOW  = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Scoreboard bench: drivers push expected results into per-DUT queues when a
//   beat is accepted; monitors pop and compare whenever a result is taken.
//   DUTs: main (64/16, 4 stages), s1 (64/64, 1 stage), s8 (8/2, 4 stages).
// -----------------------------------------------------------------------------
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    typedef struct packed {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
        logic [31:0] issue;
        logic        chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q_main[$];
    exp_t q_s1[$];
    exp_t q_s8[$];

    // ---------------- DUT signals ----------------
    logic        rst;

    logic        m_in_valid, m_in_ready, m_cin, m_sub;
    logic [63:0] m_a, m_b, m_sum;
    logic        m_out_valid, m_out_ready, m_carry, m_ovf;

    logic        sw_valid, sw_cin, sw_sub, sw_ready;
    logic [7:0]  sw_a, sw_b;
    logic [63:0] s1_a, s1_b, s1_sum;
    logic        s1_in_ready, s1_out_valid, s1_carry, s1_ovf;
    logic [7:0]  s8_sum;
    logic        s8_in_ready, s8_out_valid, s8_carry, s8_ovf;

    assign s1_a = {{56{sw_a[7]}}, sw_a};
    assign s1_b = {{56{sw_b[7]}}, sw_b};

    pipelined_adder #(.WIDTH(64), .CHUNK(16)) u_main (
        .CLK(clk), .RESET(rst), .IN_VALID(m_in_valid), .IN_READY(m_in_ready),
        .A(m_a), .B(m_b), .CARRY_IN(m_cin), .SUB(m_sub),
        .OUT_VALID(m_out_valid), .OUT_READY(m_out_ready),
        .SUM(m_sum), .CARRY(m_carry), .OVERFLOW(m_ovf)
    );

    pipelined_adder #(.WIDTH(64), .CHUNK(64)) u_s1 (
        .CLK(clk), .RESET(rst), .IN_VALID(sw_valid), .IN_READY(s1_in_ready),
        .A(s1_a), .B(s1_b), .CARRY_IN(sw_cin), .SUB(sw_sub),
        .OUT_VALID(s1_out_valid), .OUT_READY(sw_ready),
        .SUM(s1_sum), .CARRY(s1_carry), .OVERFLOW(s1_ovf)
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(2)) u_s8 (
        .CLK(clk), .RESET(rst), .IN_VALID(sw_valid), .IN_READY(s8_in_ready),
        .A(sw_a), .B(sw_b), .CARRY_IN(sw_cin), .SUB(sw_sub),
        .OUT_VALID(s8_out_valid), .OUT_READY(sw_ready),
        .SUM(s8_sum), .CARRY(s8_carry), .OVERFLOW(s8_ovf)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic [63:0] sum, input logic carry, input logic ovf);
        exp_t e;
        e.sum = sum; e.carry = carry; e.ovf = ovf; e.issue = '0; e.chk_lat = 1'b0;
        return e;
    endfunction

    // Reference: (w+1)-bit arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [64:0] m, full;
        logic [63:0] bb;
        m    = (65'd1 << w) - 65'd1;
        bb   = (sub == MODE_SUB) ? (~b & m[63:0]) : b;
        full = {1'b0, a} + {1'b0, bb} + ((sub == MODE_SUB) ? 65'd1 : {64'd0, cin});
        e.sum     = full[63:0] & m[63:0];
        e.carry   = full[w];
        e.ovf     = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
        e.issue   = '0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_main(input logic [63:0] a, input logic [63:0] b, input logic cin,
                             input logic sub, input exp_t e, input logic chk_lat);
        bit ok = 1'b0;
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            e.issue = cyc; e.chk_lat = chk_lat;
            q_main.push_back(e);
        end else begin
            check("main_in_ready_timeout", m_in_ready, 1);
        end
        @(posedge clk); #1;
        m_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((q_main.size() + q_s1.size() + q_s8.size()) != 0 && i < 100) begin
            @(negedge clk); i++;
        end
        check(name, q_main.size() + q_s1.size() + q_s8.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- monitors ----------------
    int stall_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_out_valid) begin
                if (q_main.size() == 0) begin
                    check("main_spurious_valid", m_out_valid, 0);
                end else if (m_out_ready) begin
                    exp_t e;
                    e = q_main.pop_front();
                    check("main_sum", m_sum, e.sum);
                    check("main_carry", m_carry, e.carry);
                    check("main_ovf", m_ovf, e.ovf);
                    if (e.chk_lat) check("main_latency", cyc - int'(e.issue), 4);
                end else begin
                    stall_cnt++;
                    check("main_in_ready_stall", m_in_ready, 0);
                    check("main_hold_sum", m_sum, q_main[0].sum);
                    check("main_hold_carry", m_carry, q_main[0].carry);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s1_out_valid) begin
            if (q_s1.size() == 0) begin
                check("s1_spurious_valid", s1_out_valid, 0);
            end else begin
                exp_t e;
                e = q_s1.pop_front();
                check("s1_sum", s1_sum, e.sum);
                check("s1_carry", s1_carry, e.carry);
                check("s1_ovf", s1_ovf, e.ovf);
                check("s1_latency", cyc - int'(e.issue), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s8_out_valid) begin
            if (q_s8.size() == 0) begin
                check("s8_spurious_valid", s8_out_valid, 0);
            end else begin
                exp_t e;
                e = q_s8.pop_front();
                check("s8_sum", {56'd0, s8_sum}, e.sum);
                check("s8_carry", s8_carry, e.carry);
                check("s8_ovf", s8_ovf, e.ovf);
                check("s8_latency", cyc - int'(e.issue), 4);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [63:0] ra, rb;
    logic        rcin, rsub;

    initial begin
        rst = 1'b1;
        m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = MODE_ADD;
        m_out_ready = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = MODE_ADD;
        sw_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_sum", m_sum, 0);
        check("rst_carry", m_carry, 0);
        check("rst_ovf", m_ovf, 0);
        check("rst_in_ready", m_in_ready, 1);
        check("rst_s1_valid", s1_out_valid, 0);
        check("rst_s8_valid", s8_out_valid, 0);
        @(posedge clk); #1;
        m_out_ready = 1'b1;

        // Single add, exact latency
        send_main(64'h3, 64'h5, 1'b0, MODE_ADD, mk(64'h8, 1'b0, 1'b0), 1'b1);
        drain("drain_single");

        // Directed vectors, back-to-back
        send_main(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, MODE_ADD,
                  mk(64'h0, 1'b1, 1'b0), 1'b1);
        send_main(64'h8000_0000_0000_0000, 64'h1, 1'b0, MODE_SUB,
                  mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1), 1'b1);
        send_main(64'h0, 64'h1, 1'b0, MODE_SUB,
                  mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0), 1'b1);
        send_main(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, MODE_ADD,
                  mk(64'h8000_0000_0000_0000, 1'b0, 1'b1), 1'b1);
        send_main(64'h5, 64'h3, 1'b1, MODE_SUB, mk(64'h2, 1'b1, 1'b0), 1'b1);
        send_main(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, MODE_ADD,
                  mk(64'h0000_0000_0001_0000, 1'b0, 1'b0), 1'b1);
        drain("drain_directed");

        // Backpressure: 8 random beats, OUT_READY low for 3 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                    rcin = 1'($urandom_range(0, 1));
                    rsub = 1'($urandom_range(0, 1));
                    send_main(ra, rb, rcin, rsub, model(64, ra, rb, rcin, rsub), 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 m_out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 m_out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check("stall_observed", stall_cnt >= 3, 1);

        // Reset with 3 beats in flight
        send_main(64'h11, 64'h22, 1'b0, MODE_ADD, mk(64'h33, 1'b0, 1'b0), 1'b1);
        send_main(64'h44, 64'h55, 1'b0, MODE_ADD, mk(64'h99, 1'b0, 1'b0), 1'b1);
        send_main(64'h66, 64'h77, 1'b0, MODE_ADD, mk(64'hDD, 1'b0, 1'b0), 1'b1);
        rst = 1'b1;
        q_main.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", m_out_valid, 0);
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_stale", m_out_valid, 0);
        end
        @(posedge clk); #1;
        send_main(64'h1234, 64'h1111, 1'b0, MODE_ADD, mk(64'h2345, 1'b0, 1'b0), 1'b1);
        drain("drain_after_reset");

        // Exhaustive 8-bit sweep on the 1-stage and 8/2 configurations
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                exp_t e1, e8;
                sw_a = 8'(a); sw_b = 8'(b);
                sw_sub = sw_a[0] ^ sw_b[0];
                sw_cin = sw_a[1] ^ sw_b[2];
                sw_valid = 1'b1;
                @(negedge clk);
                if (s1_in_ready && s8_in_ready) begin
                    e1 = model(64, s1_a, s1_b, sw_cin, sw_sub);
                    e8 = model(8, {56'd0, sw_a}, {56'd0, sw_b}, sw_cin, sw_sub);
                    e1.issue = cyc; e8.issue = cyc;
                    q_s1.push_back(e1);
                    q_s8.push_back(e8);
                end else begin
                    check("sweep_in_ready", {s1_in_ready, s8_in_ready}, 2'b11);
                end
                @(posedge clk); #1;
            end
        end
        sw_valid = 1'b0;
        drain("drain_sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
